// File: rtl/ifid_pkg.sv
// ifid_pkg: shared widths, NOP encoding and entry type for the IF/ID decoupling queue.
package ifid_pkg;
    localparam int DEF_PC_W    = 32;
    localparam int DEF_INSTR_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/ifid_fifo_ctrl.sv
// ifid_fifo_ctrl: circular-buffer pointers and occupancy; flush overrides push/pop.
module ifid_fifo_ctrl #(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic [AW-1:0] rd_ptr,
    output logic [AW-1:0] wr_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    logic do_push, do_pop;
    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: in-order {pc, instr} queue between fetch and decode with flush.
// Define IFID_BYPASS_EN to pass an entry straight through when the queue is empty.
module if_id_queue
    import ifid_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INSTR_W-1:0]         in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;
    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          full, empty, push, pop, byp;
`ifdef IFID_BYPASS_EN
    assign byp = empty && in_valid && !flush;
`else
    assign byp = 1'b0;
`endif
    assign in_ready  = !full;
    assign out_valid = !empty || byp;
    assign pop       = out_ready && !empty && !flush;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign push      = in_valid && !full && !flush && !(byp && out_ready);
    ifid_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .rd_ptr (rd_ptr),
        .wr_ptr (wr_ptr),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
        end
    end
    assign out_pc    = !out_valid ? '0 : byp ? in_pc : mem[rd_ptr].pc;
    assign out_instr = !out_valid ? INSTR_W'(NOP_INSTR) : byp ? in_instr : mem[rd_ptr].instr;
endmodule
